// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline buffer between execute and memory stages.
// Default build: single-register stage with a combinational in_ready.
// With EX_MEM_SKID_EN defined: 2-entry in-order FIFO with registered in_ready.
module ex_mem_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic [RD_W-1:0]   rd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic [DATA_W-1:0] out_store_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_reg_write
);

  localparam int unsigned PAY_W = 2 * DATA_W + RD_W + 4;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] out_pay_q;
  logic [PAY_W-1:0] out_pay_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             push;
  logic             pop;

  // Payload packing shared by both build variants.
  assign in_pay = {alu_zero, mem_read, mem_write, reg_write, rd, store_data, alu_result};
  assign {out_zero, out_mem_read, out_mem_write, out_reg_write,
          out_rd, out_store_data, out_result} = out_pay_q;
  assign out_valid = out_valid_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid_q & out_ready;

`ifdef EX_MEM_SKID_EN

  logic [PAY_W-1:0] mem_q [2];
  logic [PAY_W-1:0] mem_d [2];
  logic             wr_ptr_q;
  logic             wr_ptr_d;
  logic             rd_ptr_q;
  logic             rd_ptr_d;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             in_ready_q;
  logic             in_ready_d;

  assign in_ready = in_ready_q;

  // Next-state: slot writes, pointer wrap, occupancy and the registered head copy.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_pay_d   = out_pay_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_pay;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
    // Head copy only moves when something remains; otherwise last value is held.
    if (count_d != 2'd0) begin
      out_pay_d = mem_d[rd_ptr_d];
    end
    out_valid_d = (count_d != 2'd0);
    in_ready_d  = (count_d != 2'd2);
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_pay_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_pay_q   <= out_pay_d;
    end
  end

`else

  // Single stage can accept whenever it is empty or being drained this cycle.
  assign in_ready = ~out_valid_q | out_ready;

  // Next-state: flush wins over push, push reloads, lone pop empties.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pay_d   = out_pay_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (push) begin
      out_valid_d = 1'b1;
      out_pay_d   = in_pay;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage register with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_pay_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pay_q   <= out_pay_d;
    end
  end

`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Scoreboard bench for ex_mem_buffer: works for either build of the buffer.
module tb_ex_mem_buffer;

  typedef struct packed {
    logic        zero;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] sd;
    logic [31:0] res;
  } pay_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic        alu_zero = 1'b0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_zero;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_reg_write;

  pay_t cur_pay;
  pay_t exp_q[$];
  bit   rst_prev = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ex_mem_buffer #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .store_data(store_data), .rd(rd),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  assign cur_pay = {out_zero, out_mem_read, out_mem_write, out_reg_write,
                    out_rd, out_store_data, out_result};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pay_t mk(input logic [31:0] res, input logic [4:0] r, input logic rw);
    pay_t p;
    p     = '0;
    p.res = res;
    p.rd  = r;
    p.rw  = rw;
    return p;
  endfunction

  // Expected acceptance given the model occupancy.
  function automatic bit exp_ready();
`ifdef EX_MEM_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || (out_ready == 1'b1);
`endif
  endfunction

  // Monitor: compares DUT outputs with the model head, pops on consumption.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      check("in_ready", 128'(in_ready), 128'(exp_ready()));
      if (rst_prev) check("reset_payload", 128'(cur_pay), 128'(0));
      if (out_valid && exp_q.size() != 0) begin
        check("payload", 128'(cur_pay), 128'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Driver: applies one cycle of inputs and records accepted entries.
  task automatic drive(input bit rst, input bit iv, input bit fl, input bit ordy, input pay_t p);
    @(negedge clk);
    reset      = rst;
    in_valid   = iv;
    flush      = fl;
    out_ready  = ordy;
    alu_result = p.res;
    alu_zero   = p.zero;
    store_data = p.sd;
    rd         = p.rd;
    mem_read   = p.mr;
    mem_write  = p.mw;
    reg_write  = p.rw;
    #2;
    if (rst || fl) exp_q.delete();
    else if (iv && in_ready) exp_q.push_back(p);
    rst_prev = rst;
  endtask

  initial begin
    pay_t p;
    // Reset, then a single entry with the consumer ready.
    drive(1, 0, 0, 1, mk(0, 0, 0));
    drive(1, 0, 0, 1, mk(0, 0, 0));
    drive(0, 1, 0, 1, mk(32'h5, 5'd3, 1'b1));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    // Back-pressure: two pushes while stalled, then drain in order.
    drive(0, 1, 0, 0, mk(32'hA, 5'd1, 1'b1));
    drive(0, 1, 0, 0, mk(32'hB, 5'd2, 1'b1));
    drive(0, 0, 0, 0, mk(0, 0, 0));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    // Simultaneous push and pop at occupancy one.
    drive(0, 1, 0, 0, mk(32'h11, 5'd4, 1'b0));
    drive(0, 1, 0, 1, mk(32'h22, 5'd5, 1'b1));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    // Flush with a same-cycle push that must be dropped.
    drive(0, 1, 0, 0, mk(32'h1, 5'd6, 1'b1));
    drive(0, 1, 0, 0, mk(32'h2, 5'd7, 1'b1));
    drive(0, 1, 1, 0, mk(32'h33, 5'd8, 1'b1));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    // Store entry then reset while stalled: outputs must clear.
    p = '0; p.zero = 1'b1; p.mw = 1'b1; p.sd = 32'hDEAD_BEEF; p.res = 32'h40;
    drive(0, 1, 0, 0, p);
    drive(0, 0, 0, 0, mk(0, 0, 0));
    drive(1, 0, 0, 0, mk(0, 0, 0));
    drive(0, 0, 0, 0, mk(0, 0, 0));
    drive(0, 0, 0, 1, mk(0, 0, 0));
    // Randomized traffic including illegal mem_read+mem_write combinations.
    for (int i = 0; i < 3000; i++) begin
      p.res  = $urandom;
      p.sd   = $urandom;
      p.rd   = 5'($urandom_range(0, 31));
      p.zero = 1'($urandom_range(0, 1));
      p.mr   = 1'($urandom_range(0, 1));
      p.mw   = 1'($urandom_range(0, 1));
      p.rw   = 1'($urandom_range(0, 1));
      drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 6), p);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, mk(0, 0, 0));
    check("drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_buffer.md
EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 Parameter DATA_W, default 32: width of ALU result and store data.
REQ-002 Parameter RD_W, default 5: destination register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  execute stage presents a valid entry.
REQ-006 in_ready  output  1  buffer accepts the entry this cycle.
REQ-007 alu_result  input  DATA_W  ALU result.
REQ-008 alu_zero  input  1  ALU zero flag (CBZ).
REQ-009 store_data  input  DATA_W  data for STR.
REQ-010 rd  input  RD_W  destination register.
REQ-011 mem_read, mem_write, reg_write  input  1 each  control bits for LDR, STR and write-back.
REQ-012 flush  input  1  discard all held entries (branch taken).
REQ-013 out_valid  output  1  head entry valid to the memory stage.
REQ-014 out_ready  input  1  memory stage consumes the head entry.
REQ-015 out_result, out_zero, out_store_data, out_rd, out_mem_read, out_mem_write, out_reg_write  output  match inputs  head entry payload.

Function
REQ-016 The block shall be a 2-entry in-order FIFO; push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-017 in_ready shall be a registered signal, 1 when occupancy < 2, with no combinational path from out_ready.
REQ-018 Latency: an entry pushed in cycle N shall appear on out_* with out_valid=1 in cycle N+1 when the buffer was empty.
REQ-019 Payload bits shall be captured only on push; out_* shall hold steady while out_valid=1 and out_ready=0.
REQ-020 Occupancy 1 with push and pop in the same cycle: occupancy stays 1 and the new entry becomes head next cycle.
REQ-021 Occupancy 2: in_ready=0, in_valid ignored; a pop frees one slot and in_ready=1 next cycle.
REQ-022 Occupancy 0 with pop asserted: no effect; out_valid stays 0.
REQ-023 Read/write pointers shall be 1 bit and wrap 1->0.
REQ-024 flush shall set occupancy to 0 and out_valid to 0 next cycle, drop any same-cycle push, and set in_ready=1.
REQ-025 When out_valid=0, out_* payload shall hold its last value and is don't-care to consumers.
REQ-026 mem_read and mem_write both 1 on push is illegal; the block shall pass it through unchanged.

Reset
REQ-027 reset shall take priority over flush and push, and the block shall have no asynchronous reset behaviour.
REQ-028 On reset: occupancy 0, pointers 0, out_valid 0, in_ready 1, all payload registers and outputs 0.
REQ-029 Reset asserted mid-transfer shall discard all held entries without emitting them.

Configuration
REQ-030 Macro EX_MEM_SKID_EN defined: 2-entry behaviour per REQ-016..REQ-024.
REQ-031 EX_MEM_SKID_EN undefined: single-register stage; in_ready = !out_valid | out_ready (combinational), push loads the register, flush/reset clear out_valid; latency still 1 cycle.

Verification
REQ-032 Reset, then push alu_result=0x0000_0005, rd=3, reg_write=1 with out_ready=1 -> next cycle out_valid=1, out_result=0x5, out_rd=3, out_reg_write=1.
REQ-033 out_ready=0, push 0xA then 0xB -> in_ready=0 after second push; out_ready=1 -> 0xA then 0xB in order, in_ready=1 after first pop.
REQ-034 Occupancy 1 (0x11) with push 0x22 and pop same cycle -> out_result=0x22 next cycle, occupancy 1, no loss or duplicate.
REQ-035 Two entries held, flush=1 with in_valid=1 (0x33) -> next cycle out_valid=0, in_ready=1, 0x33 never emitted.
REQ-036 alu_zero=1, mem_write=1, store_data=0xDEAD_BEEF pushed, then reset asserted while out_ready=0 -> next cycle out_valid=0, all out_* = 0.
REQ-037 Repeat REQ-032 and REQ-033 with EX_MEM_SKID_EN undefined -> in_ready follows out_ready combinationally when full; order preserved.
